// File: rtl/keccak_pkg.sv
// Shared Keccak constants, the round-count helper and FSM state encodings for the step engines.
package keccak_pkg;

  localparam int unsigned SLICE_W    = 25;
  localparam int unsigned LANE00_BIT = 0;

  localparam logic [7:0] RC_LFSR_INIT = 8'h01;
  localparam logic [7:0] RC_LFSR_TAPS = 8'h71;

  // Rounds for a permutation with lane width 2^l.
  function automatic int unsigned num_rounds(input int unsigned l);
    return 12 + 2 * l;
  endfunction

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StGen  = 3'd1;
  localparam state_t StRd   = 3'd2;
  localparam state_t StWr   = 3'd3;
  localparam state_t StDone = 3'd4;

endpackage

// File: rtl/keccak_rc_lfsr.sv
// 8-bit round-constant LFSR (x^8+x^6+x^5+x^4+1); bit 0 is rc(t) for the current step t.
module keccak_rc_lfsr
  import keccak_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  output logic rc_bit
);

  logic [7:0] lfsr_q, lfsr_d;

  // Load has priority so a new pass always starts from the seed.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = RC_LFSR_INIT;
    end else if (step) begin
      lfsr_d = {lfsr_q[6:0], 1'b0} ^ (lfsr_q[7] ? RC_LFSR_TAPS : 8'h00);
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= RC_LFSR_INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rc_bit = lfsr_q[0];

endmodule

// File: rtl/addrc_slice_engine.sv
// Keccak iota over slice-organised state memory. Round constant bits are generated on the fly
// by stepping the LFSR 7*ir+L+1 times, then every slice is read and rewritten with bit 0
// XORed by its RC bit (non-zero only for slices z = 2^j-1).
module addrc_slice_engine
  import keccak_pkg::*;
#(
  parameter  int unsigned LANE_W = 64,
  parameter  int unsigned ITER_W = 5,
  localparam int unsigned L      = $clog2(LANE_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ITER_W-1:0]  iteration,
  output logic [L-1:0]       mem_addr,
  output logic               mem_rd_en,
  input  logic [SLICE_W-1:0] mem_rdata,
  output logic               mem_wr_en,
  output logic [SLICE_W-1:0] mem_wdata,
  output logic               busy,
  output logic               finish,
  output logic               err
);

  localparam int unsigned NumRounds = num_rounds(L);
  // GEN counter must reach 7*ir+L for the largest encodable ir.
  localparam int unsigned TMax      = 7 * ((1 << ITER_W) - 1) + L;
  localparam int unsigned TW        = $clog2(TMax + 1);

  state_t            state_q, state_d;
  logic [ITER_W-1:0] ir_q, ir_d;
  logic [TW-1:0]     t_q, t_d;
  logic [L-1:0]      z_q, z_d;
  logic [L:0]        rcbits_q, rcbits_d;
  logic              err_q, err_d;

  logic              lfsr_load, lfsr_step, rc_bit;
  logic [TW-1:0]     t_base, t_last;
  logic              rcb;

  keccak_rc_lfsr u_rc_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .step   (lfsr_step),
    .rc_bit (rc_bit)
  );

  assign t_base = TW'(ir_q) * TW'(7);
  assign t_last = t_base + TW'(L);

  // Next-state: FSM, step counter t, slice counter z and captured RC bits.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    t_d       = t_q;
    z_d       = z_q;
    rcbits_d  = rcbits_q;
    err_d     = err_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          ir_d = iteration;
          if (32'(iteration) >= NumRounds) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d     = 1'b0;
            lfsr_load = 1'b1;
            t_d       = '0;
            rcbits_d  = '0;
            state_d   = StGen;
          end
        end
      end
      StGen: begin
        lfsr_step = 1'b1;
        // Only steps 7*ir .. 7*ir+L contribute to this round's constant.
        for (int unsigned j = 0; j <= L; j++) begin
          if (t_q == t_base + TW'(j)) begin
            rcbits_d[j] = rc_bit;
          end
        end
        if (t_q == t_last) begin
          z_d     = '0;
          state_d = StRd;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      StRd: begin
        state_d = StWr;
      end
      StWr: begin
        if (z_q == L'(LANE_W - 1)) begin
          state_d = StDone;
        end else begin
          z_d     = z_q + L'(1);
          state_d = StRd;
        end
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any pass at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ir_q     <= '0;
      t_q      <= '0;
      z_q      <= '0;
      rcbits_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      t_q      <= t_d;
      z_q      <= z_d;
      rcbits_q <= rcbits_d;
      err_q    <= err_d;
    end
  end

  // RC bit for the current slice: bit j of the constant lives in slice 2^j-1.
  always_comb begin
    rcb = 1'b0;
    for (int unsigned j = 0; j <= L; j++) begin
      if (z_q == L'((1 << j) - 1)) begin
        rcb = rcbits_q[j];
      end
    end
  end

  // Outputs decode straight from state so reset clears them without a clock edge.
  always_comb begin
    mem_rd_en = (state_q == StRd);
    mem_wr_en = (state_q == StWr);
    mem_addr  = (mem_rd_en || mem_wr_en) ? z_q : '0;
    mem_wdata = mem_wr_en ? (mem_rdata ^ (SLICE_W'(rcb) << LANE00_BIT)) : '0;
    busy      = (state_q != StIdle);
    finish    = (state_q == StDone);
    err       = finish && err_q;
  end

endmodule

// File: tb/tb_addrc_slice_engine.sv
// Bench for addrc_slice_engine: a 64-lane and an 8-lane instance, each with a behavioural
// slice memory. Expected slice writes are queued when a pass is launched and checked as the
// DUT issues them.
module tb_addrc_slice_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start0, start1;
  logic [4:0]  iter0, iter1;
  logic [5:0]  addr0;
  logic [2:0]  addr1;
  logic        rd0, rd1, wr0, wr1;
  logic [24:0] rdat0 = '0, rdat1 = '0;
  logic [24:0] wdat0, wdat1;
  logic        busy0, busy1, fin0, fin1, err0, err1;

  logic [24:0] mem0 [64];
  logic [24:0] mem1 [8];
  logic [24:0] snap0 [64];
  logic [24:0] snap1 [8];

  typedef struct packed {
    logic [5:0]  addr;
    logic [24:0] data;
  } wr_exp_t;

  wr_exp_t q0[$];
  wr_exp_t q1[$];

  int total = 0;
  int bad   = 0;
  int rd0n, wr0n, rd1n, wr1n;

  addrc_slice_engine #(.LANE_W(64), .ITER_W(5)) u_dut64 (
    .clk       (clk),
    .rst       (rst),
    .start     (start0),
    .iteration (iter0),
    .mem_addr  (addr0),
    .mem_rd_en (rd0),
    .mem_rdata (rdat0),
    .mem_wr_en (wr0),
    .mem_wdata (wdat0),
    .busy      (busy0),
    .finish    (fin0),
    .err       (err0)
  );

  addrc_slice_engine #(.LANE_W(8), .ITER_W(5)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .iteration (iter1),
    .mem_addr  (addr1),
    .mem_rd_en (rd1),
    .mem_rdata (rdat1),
    .mem_wr_en (wr1),
    .mem_wdata (wdat1),
    .busy      (busy1),
    .finish    (fin1),
    .err       (err1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference Keccak rc(t).
  function automatic logic rc_ref(input int t);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < t; i++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h71 : 8'h00);
    return r[0];
  endfunction

  function automatic logic rcb_ref(input int ir, input int l, input int z);
    for (int j = 0; j <= l; j++) begin
      if (z == (1 << j) - 1) return rc_ref(7 * ir + j);
    end
    return 1'b0;
  endfunction

  // Synchronous slice memories.
  always @(posedge clk) begin
    if (rd0) rdat0 <= mem0[addr0];
    if (wr0) mem0[addr0] = wdat0;
    if (rd1) rdat1 <= mem1[addr1];
    if (wr1) mem1[addr1] = wdat1;
  end

  // Write monitors: pop the scoreboard on every write strobe.
  always @(negedge clk) begin
    wr_exp_t e;
    if (rst) begin
      chk("rdwr_excl64", 64'(rd0 & wr0), 64'd0);
      chk("rdwr_excl8", 64'(rd1 & wr1), 64'd0);
    end
    if (rd0) rd0n++;
    if (rd1) rd1n++;
    if (wr0) begin
      wr0n++;
      chk("wr_expected64", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("wr_addr64", 64'(addr0), 64'(e.addr));
        chk("wr_data64", 64'(wdat0), 64'(e.data));
      end
    end
    if (wr1) begin
      wr1n++;
      chk("wr_expected8", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("wr_addr8", 64'(addr1), 64'(e.addr));
        chk("wr_data8", 64'(wdat1), 64'(e.data));
      end
    end
  end

  task automatic set_start(input bit s, input logic v);
    if (s) start1 = v;
    else   start0 = v;
  endtask

  // Queue a pass's expected writes, launch it and check latency, err and the handshake.
  task automatic run_pass(input bit s, input int ir, input bit hold, input bit repulse);
    int w, l, explat, lat, gaps;
    bit experr;
    logic f, b, e;
    logic [24:0] d;
    w      = s ? 8 : 64;
    l      = s ? 3 : 6;
    experr = (ir >= 12 + 2 * l);
    explat = experr ? 1 : 7 * ir + l + 1 + 2 * w + 1;
    if (!experr) begin
      for (int z = 0; z < w; z++) begin
        if (s) begin
          d = mem1[z] ^ 25'(rcb_ref(ir, l, z));
          q1.push_back('{addr: 6'(z), data: d});
        end else begin
          d = mem0[z] ^ 25'(rcb_ref(ir, l, z));
          q0.push_back('{addr: 6'(z), data: d});
        end
      end
    end
    rd0n = 0; wr0n = 0; rd1n = 0; wr1n = 0;
    @(negedge clk);
    if (s) iter1 = 5'(ir);
    else   iter0 = 5'(ir);
    set_start(s, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_start(s, 1'b0);
    lat  = 1;
    gaps = 0;
    f    = 1'b0;
    e    = 1'b0;
    while (lat < 3000) begin
      f = s ? fin1 : fin0;
      b = s ? busy1 : busy0;
      e = s ? err1 : err0;
      if (!b) gaps++;
      if (f) break;
      if (repulse && lat == 10) set_start(s, 1'b1);
      if (repulse && lat == 12) set_start(s, 1'b0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("latency s%0d ir%0d", s, ir), 64'(lat), 64'(explat));
    chk($sformatf("err s%0d ir%0d", s, ir), 64'(e), 64'(experr));
    chk($sformatf("busy_gaps s%0d ir%0d", s, ir), 64'(gaps), 64'd0);
    if (hold) set_start(s, 1'b0);
    @(posedge clk);
    #1;
    chk($sformatf("idle_after s%0d ir%0d", s, ir),
        s ? 64'({fin1, busy1, err1}) : 64'({fin0, busy0, err0}), 64'd0);
    chk($sformatf("queue_drained s%0d ir%0d", s, ir),
        64'(s ? q1.size() : q0.size()), 64'd0);
    chk($sformatf("rd_count s%0d ir%0d", s, ir),
        64'(s ? rd1n : rd0n), 64'(experr ? 0 : w));
    chk($sformatf("wr_count s%0d ir%0d", s, ir),
        64'(s ? wr1n : wr0n), 64'(experr ? 0 : w));
  endtask

  initial begin
    logic [63:0] mask;
    int other, n;

    rst = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    iter0 = '0; iter1 = '0;
    for (int z = 0; z < 64; z++) mem0[z] = '0;
    for (int z = 0; z < 8; z++) mem1[z] = '0;
    #12;
    chk("reset_outs64", 64'({busy0, fin0, err0, rd0, wr0, addr0, wdat0}), 64'd0);
    chk("reset_outs8", 64'({busy1, fin1, err1, rd1, wr1, addr1, wdat1}), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // ir=0 on zero memory: only slice 0 becomes 1.
    run_pass(1'b0, 0, 1'b0, 1'b0);
    chk("ir0_slice0", 64'(mem0[0]), 64'd1);
    other = 0;
    for (int z = 1; z < 64; z++) if (mem0[z] != 0) other++;
    chk("ir0_others", 64'(other), 64'd0);

    // ir=1 on random memory.
    for (int z = 0; z < 64; z++) begin
      mem0[z]  = 25'($urandom);
      snap0[z] = mem0[z];
    end
    run_pass(1'b0, 1, 1'b0, 1'b0);
    mask = '0; other = 0;
    for (int z = 0; z < 64; z++) begin
      if (mem0[z] != snap0[z]) mask[z] = 1'b1;
      if (((mem0[z] ^ snap0[z]) & ~25'h1) != 0) other++;
    end
    chk("ir1_flip_mask", mask, 64'h8082);
    chk("ir1_only_bit0", 64'(other), 64'd0);

    // ir=23 twice restores memory.
    for (int z = 0; z < 64; z++) snap0[z] = mem0[z];
    run_pass(1'b0, 23, 1'b0, 1'b0);
    mask = '0;
    for (int z = 0; z < 64; z++) if (mem0[z] != snap0[z]) mask[z] = 1'b1;
    chk("ir23_flip_mask", mask, 64'h8000000080008008);
    run_pass(1'b0, 23, 1'b0, 1'b0);
    other = 0;
    for (int z = 0; z < 64; z++) if (mem0[z] != snap0[z]) other++;
    chk("ir23_twice_restore", 64'(other), 64'd0);

    // 8-lane: ir=1 flips slices 1 and 7; ir=18 is out of range.
    for (int z = 0; z < 8; z++) begin
      mem1[z]  = 25'($urandom);
      snap1[z] = mem1[z];
    end
    run_pass(1'b1, 1, 1'b0, 1'b0);
    mask = '0;
    for (int z = 0; z < 8; z++) if (mem1[z] != snap1[z]) mask[z] = 1'b1;
    chk("w8_ir1_flip_mask", mask, 64'h82);
    for (int z = 0; z < 8; z++) snap1[z] = mem1[z];
    run_pass(1'b1, 18, 1'b0, 1'b0);
    other = 0;
    for (int z = 0; z < 8; z++) if (mem1[z] != snap1[z]) other++;
    chk("w8_err_untouched", 64'(other), 64'd0);

    // start held high, then re-pulsed while busy.
    run_pass(1'b1, 2, 1'b1, 1'b0);
    run_pass(1'b1, 4, 1'b0, 1'b1);

    // Reset asserted while writing slice 10.
    for (int z = 0; z < 64; z++) mem0[z] = mem0[z] ^ ((mem0[z] & 25'h1) ? 25'h0 : 25'h2);
    for (int z = 0; z < 64; z++) q0.push_back('{addr: 6'(z), data: mem0[z] ^ 25'(rcb_ref(5, 6, z))});
    @(negedge clk);
    iter0  = 5'd5;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    n = 0;
    while (!(wr0 && addr0 == 6'd10) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_wr10", 64'({wr0, addr0}), 64'({1'b1, 6'd10}));
    #2;
    rst = 1'b0;
    #1;
    chk("mid_reset_outs", 64'({busy0, fin0, err0, rd0, wr0, addr0, wdat0}), 64'd0);
    q0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_pass(1'b0, 3, 1'b0, 1'b0);
    run_pass(1'b0, 24, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
